// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: operation codes, ALUOp encodings
// and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  // 4-bit operation codes understood by ALU_64_Bit.
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_NOR = 4'b1100
  } alu_opcode_e;

  // Main-decoder ALUOp field.
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_NOR    = 2'b11
  } aluop_e;

endpackage

// File: rtl/ALU_64_Bit.sv
// Existing 64-bit combinational ALU driven by the issue unit.
module ALU_64_Bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  ALUOp,
  output logic [63:0] Result,
  output logic        Zero
);

  // Operation select; unknown codes produce zero.
  always_comb begin
    Result = '0;
    case (ALUOp)
      4'b0000: Result = a & b;
      4'b0001: Result = a | b;
      4'b0010: Result = a + b;
      4'b0110: Result = a - b;
      4'b1100: Result = ~(a | b);
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == 64'd0);

endmodule

// File: rtl/alu_ctrl_decode.sv
// ALU control decode: maps ALUOp, funct3 and funct7[5] to a 4-bit operation
// code and flags combinations that have no legal meaning.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output alu_opcode_e operation,
  output logic        illegal
);

  // Decode table; unmatched R-type fields fall back to AND and raise illegal.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    operation = OP_AND;
    illegal   = 1'b0;
    unique case (aluop_e'(alu_op))
      ALUOP_MEM:    operation = OP_ADD;
      ALUOP_BRANCH: operation = OP_SUB;
      ALUOP_NOR:    operation = OP_NOR;
      ALUOP_RTYPE: begin
        case ({funct7_b5, funct3})
          4'b0_000: operation = OP_ADD;
          4'b1_000: operation = OP_SUB;
          4'b0_111: operation = OP_AND;
          4'b0_110: operation = OP_OR;
          default: begin
            operation = OP_AND;
            illegal   = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Pipelined ALU issue unit: decodes control fields, registers the request in
// S1, runs it through ALU_64_Bit and queues Result/Zero/illegal in a 2-entry
// output buffer. Valid/ready handshakes on both sides.
module alu_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  alu_opcode_e      dec_op;
  logic             dec_illegal;

  logic             s1_valid_q, s1_valid_d;
  alu_opcode_e      s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_illegal_q, s1_illegal_d;

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [WIDTH-1:0] buf_result_q  [DEPTH];
  logic             buf_zero_q    [DEPTH];
  logic             buf_illegal_q [DEPTH];

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             accept, pop, s1_advance;

  alu_ctrl_decode u_decode (
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  ALU_64_Bit u_alu (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .ALUOp  (s1_op_q),
    .Result (alu_result),
    .Zero   (alu_zero)
  );

  // Handshakes: S1 may move into the buffer if there is room or the head
  // leaves this cycle; a pop therefore frees in_ready combinationally.
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign s1_advance = s1_valid_q & ((count_q != FULL) | pop);
  assign in_ready   = ~reset & (~s1_valid_q | s1_advance);
  assign accept     = in_valid & in_ready;

  // S1 next state: load on accept, otherwise drain when it advances.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_illegal_d = s1_illegal_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = dec_op;
      s1_a_d       = a;
      s1_b_d       = b;
      s1_illegal_d = dec_illegal;
    end else if (s1_advance) begin
      s1_valid_d   = 1'b0;
    end
  end

  // Buffer bookkeeping: pointers wrap naturally at depth 2, count tracks fill.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (s1_advance) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)        rd_ptr_d = rd_ptr_q + 1'b1;
    case ({s1_advance, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_AND;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_illegal_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_illegal_q <= s1_illegal_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Buffer storage written when S1 advances.
  always_ff @(posedge clk) begin
    // NOTE: entries are not reset; count/pointers define validity and the
    // outputs are masked when empty, so stale data is never visible.
    if (s1_advance) begin
      buf_result_q[wr_ptr_q]  <= alu_result;
      buf_zero_q[wr_ptr_q]    <= alu_zero;
      buf_illegal_q[wr_ptr_q] <= s1_illegal_q;
    end
  end

  // Head entry presented to the consumer, forced to zero when empty.
  always_comb begin
    result  = '0;
    zero    = 1'b0;
    illegal = 1'b0;
    if (out_valid) begin
      result  = buf_result_q[rd_ptr_q];
      zero    = buf_zero_q[rd_ptr_q];
      illegal = buf_illegal_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_alu_ctrl_pipe;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_b5 = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        zero;
  logic        illegal;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: results waiting at the output and the one in flight.
  ent_t mq[$];
  ent_t s1_e;
  bit   s1_v = 1'b0;

  alu_ctrl_pipe #(.WIDTH(64), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the instruction must compute, straight from the control-field table.
  function automatic ent_t model_alu(input logic [1:0] op, input logic [2:0] f3,
                                     input logic f7, input logic [63:0] x,
                                     input logic [63:0] y);
    ent_t e;
    e.ill = 1'b0;
    case (op)
      2'd0: e.res = x + y;
      2'd1: e.res = x - y;
      2'd3: e.res = ~(x | y);
      default: begin
        if      ({f7, f3} == 4'b0000) e.res = x + y;
        else if ({f7, f3} == 4'b1000) e.res = x - y;
        else if ({f7, f3} == 4'b0111) e.res = x & y;
        else if ({f7, f3} == 4'b0110) e.res = x | y;
        else begin
          e.res = x & y;
          e.ill = 1'b1;
        end
      end
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  // The unit holds at most three requests; a pop frees a slot immediately.
  function automatic bit exp_in_ready();
    return !reset && (((mq.size() + int'(s1_v)) < 3) || out_ready);
  endfunction

  // Model update on each clock edge (or asynchronous reset).
  initial forever begin : model_update
    bit do_pop, do_acc;
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      s1_v = 1'b0;
    end else begin
      do_pop = (mq.size() != 0) && out_ready;
      do_acc = in_valid && exp_in_ready();
      if (do_pop) void'(mq.pop_front());
      if (s1_v && mq.size() < 2) begin
        mq.push_back(s1_e);
        s1_v = 1'b0;
      end
      if (do_acc) begin
        s1_e = model_alu(alu_op, funct3, funct7_b5, a, b);
        s1_v = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial forever begin : compare
    @(negedge clk);
    if (reset) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end else begin
      check("in_ready", 64'(in_ready), 64'(exp_in_ready()));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("result", result, mq[0].res);
        check("zero", 64'(zero), 64'(mq[0].zero));
        check("illegal", 64'(illegal), 64'(mq[0].ill));
      end else begin
        check("empty_result", result, 64'd0);
        check("empty_zero", 64'(zero), 64'd0);
        check("empty_illegal", 64'(illegal), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single request with out_ready=1; checks latency and literal result.
  task automatic send_expect(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic [63:0] va, input logic [63:0] vb,
                             input logic [63:0] er, input logic ez, input logic ei,
                             input string nm);
    tick();
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7_b5 = f7; a = va; b = vb;
    out_ready = 1'b1;
    #1 check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_not_yet"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({nm, "_out_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_result"}, result, er);
    check({nm, "_zero"}, 64'(zero), 64'(ez));
    check({nm, "_illegal"}, 64'(illegal), 64'(ei));
  endtask

  logic [2:0] legal_f3 [3];
  logic       acc_prev;

  initial begin
    legal_f3[0] = 3'b000;
    legal_f3[1] = 3'b111;
    legal_f3[2] = 3'b110;

    repeat (3) tick();
    reset = 1'b0;
    #1 check("post_reset_in_ready", 64'(in_ready), 64'd1);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);

    // Opcode sweep.
    send_expect(2'b10, 3'b111, 1'b0, 64'hAE, 64'h18C, 64'h8C, 1'b0, 1'b0, "sweep_and");
    send_expect(2'b10, 3'b110, 1'b0, 64'hAE, 64'h18C, 64'h1AE, 1'b0, 1'b0, "sweep_or");
    send_expect(2'b00, 3'b000, 1'b0, 64'hAE, 64'h18C, 64'h23A, 1'b0, 1'b0, "sweep_add");
    send_expect(2'b11, 3'b000, 1'b0, 64'hAE, 64'h18C, 64'hFFFF_FFFF_FFFF_FE51, 1'b0, 1'b0,
                "sweep_nor");
    // Branch zero.
    send_expect(2'b01, 3'b000, 1'b0, 64'h66, 64'h66, 64'h0, 1'b1, 1'b0, "branch_eq");
    send_expect(2'b01, 3'b000, 1'b0, 64'h66, 64'h0, 64'h66, 1'b0, 1'b0, "branch_ne");
    // Illegal decode, then a legal request clears the flag.
    send_expect(2'b10, 3'b111, 1'b1, 64'hAE, 64'h18C, 64'h8C, 1'b0, 1'b1, "illegal");
    send_expect(2'b10, 3'b000, 1'b0, 64'hAE, 64'h18C, 64'h23A, 1'b0, 1'b0, "after_illegal");

    // Backpressure: three taken, the fourth held until a pop.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alu_op = 2'b00; funct3 = 3'b000; funct7_b5 = 1'b0;
      a = 64'(i * 16 + 1); b = 64'h100;
      #1 check("bp_in_ready", 64'(in_ready), 64'(i < 3));
      tick();
    end
    check("bp_head0_valid", 64'(out_valid), 64'd1);
    check("bp_head0", result, 64'h101);
    out_ready = 1'b1;
    #1 check("bp_reenable", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check("bp_stream_valid", 64'(out_valid), 64'd1);
      check("bp_stream_result", result, 64'(j * 16 + 1 + 256));
    end
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with two results buffered.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 2'b00; funct3 = 3'b000; funct7_b5 = 1'b0;
    a = 64'h55; b = 64'h22;
    tick();
    a = 64'h11; b = 64'h22;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    check("pre_reset_head", result, 64'h77);
    reset = 1'b1;
    #1 check("mid_reset_out_valid", 64'(out_valid), 64'd0);
    check("mid_reset_result", result, 64'd0);
    check("mid_reset_zero", 64'(zero), 64'd0);
    check("mid_reset_in_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1 check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic; a refused request is held until taken.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc_prev = in_valid && in_ready;
      @(posedge clk);
      #2;
      if (!in_valid || acc_prev) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        alu_op    = 2'($urandom);
        funct3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 2)];
        funct7_b5 = ($urandom_range(0, 3) == 0);
        a         = {$urandom, $urandom};
        b         = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      end
      if (cyc < 1000) out_ready = ($urandom_range(0, 3) == 0);
      else            out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain and confirm idle.
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("final_out_valid", 64'(out_valid), 64'd0);
    check("final_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Pipelined ALU issue unit. It decodes RISC-V control fields (ALUOp, funct3, funct7[5]) into the 4-bit `ALU_64_Bit` operation code and registers operands. It drives the existing 64-bit ALU and returns Result/Zero through a 2-entry output buffer with valid/ready handshakes on both sides. It sits between the decode stage and writeback/branch logic, and is the producer side of the ALU operation interface.

## Interface
- `WIDTH`, 64: operand/result width; must match `ALU_64_Bit`.
- `DEPTH`, 2: output buffer entries; fixed at 2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit accepts the request this cycle.
- `alu_op` input 2: 00 load/store, 01 branch, 10 R-type, 11 NOR.
- `funct3` input 3: instruction funct3.
- `funct7_b5` input 1: instruction bit 30.
- `a`, `b` input WIDTH: operands.
- `out_valid` output 1: result at buffer head.
- `out_ready` input 1: consumer takes the head this cycle.
- `result` output WIDTH: ALU Result.
- `zero` output 1: ALU Zero (result == 0).
- `illegal` output 1: the request's control fields had no legal decode.

## Operation
- Decode to operation codes: AND=0000, OR=0001, ADD=0010, SUB=0110, NOR=1100.
  - `alu_op`=00 → ADD.
  - 01 → SUB.
  - 11 → NOR.
  - 10 with {funct7_b5,funct3}: 0_000 → ADD, 1_000 → SUB, 0_111 → AND, 0_110 → OR.
  - Any other combination → op 0000, with `illegal`=1 carried alongside the result. The result is still produced.
- Stage S1 register holds valid, op, a, b, illegal. It loads on accept (`in_valid & in_ready`).
- S1 feeds the combinational `ALU_64_Bit`. Result, Zero and illegal are pushed into the buffer when S1 advances.
- S1 advances when `s1_valid` and (count < 2, or count == 2 and a pop occurs this cycle).
- `in_ready` = !s1_valid | s1_advance; forced 0 while `reset` is high.
- Pop = `out_valid & out_ready`. Push and pop in the same cycle leave count unchanged, including when full.
- Buffer: 2 entries, read/write pointers wrap modulo 2, count 0..2.
- `out_valid` = count != 0. `result`/`zero`/`illegal` show the head entry, and are 0 when empty.
- No arithmetic inside this unit; width truncation and overflow behaviour are those of `ALU_64_Bit`.

## Timing
- Reset values:
  - S1 invalid.
  - Count 0, pointers 0.
  - `out_valid`=0, `result`=0, `zero`=0, `illegal`=0.
  - `in_ready`=1 on the first cycle after deassertion.
- Latency: a request accepted at edge k is at the buffer head after edge k+1. `out_valid` is high in the cycle following edge k+1.
- Throughput: 1 request/cycle sustained with `out_ready`=1.
- Backpressure with `out_ready`=0: accepts 3 requests (2 buffered + 1 in S1), then `in_ready`=0. A single pop re-enables `in_ready` combinationally in that same cycle.
- Order is strictly FIFO. No request is dropped or duplicated.
- `in_valid` with `in_ready`=0: the request is not taken and the requester must hold it.
- Reset mid-operation: S1 and all buffer contents are discarded immediately (asynchronous). Outputs go to their reset values.

## Structure
- Shared package `alu_pkg`:
  - operation-code constants (AND, OR, ADD, SUB, NOR);
  - ALUOp constants;
  - the `WIDTH` default.
- Sub-modules:
  - instantiate the existing `ALU_64_Bit` unchanged;
  - the decode function is natural as a small combinational sub-module `alu_ctrl_decode` (inputs alu_op, funct3, funct7_b5; outputs operation, illegal).
- The buffer is inline registers; no generic FIFO module is needed at depth 2.

## Test plan
- Opcode sweep: a=0xAE, b=0x18C, `out_ready`=1, with these control fields:
  - alu_op=10 funct3=111 → result 0x8C;
  - funct3=110 → 0x1AE;
  - alu_op=00 → 0x23A;
  - alu_op=11 → 0xFFFF_FFFF_FFFF_FE51.
  - Each response arrives 2 cycles after accept, with zero=0.
- Branch zero: alu_op=01, a=b=0x66 → result 0, zero=1. Then a=0x66, b=0 → result 0x66, zero=0.
- Illegal decode: alu_op=10, funct7_b5=1, funct3=111 → illegal=1, result=a&b. The next legal request has illegal=0.
- Backpressure: `out_ready`=0, four back-to-back requests → first three accepted and `in_ready`=0 on the fourth. Then raise `out_ready` → all four results emerge in order, no gaps once streaming.
- Full simultaneous push/pop: count=2 with S1 valid and `out_ready`=1 held → one pop and one push per cycle, count stays 2, order preserved.
- Reset mid-stream: assert `reset` with 2 entries buffered → `out_valid`, `result` and `zero` are 0 immediately. After release `in_ready`=1 and no stale result appears.
